// File: rtl/hazard_pkg.sv
// Shared types and helpers for the load-use hazard / stall sequencer block.
package hazard_pkg;

  localparam int unsigned REG_W_DEF = 5;
  localparam logic [REG_W_DEF-1:0] ZERO_REG = '0;

  typedef logic [REG_W_DEF-1:0] reg_idx_t;

  // Counter width that can hold cyc; a zero-length stall still needs one bit.
  function automatic int unsigned stall_cnt_w(int unsigned cyc);
    int unsigned m;
    m = (cyc == 0) ? 1 : cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/stall_timer.sv
// Programmable-length stall counter: a trigger at idle loads CYC, busy while non-zero.
module stall_timer
  import hazard_pkg::*;
#(
  parameter int unsigned CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic trig,
  output logic busy
);

  localparam int unsigned W = stall_cnt_w(CYC);
  localparam logic [W-1:0] LOAD = W'(CYC);

  logic [W-1:0] cnt_q, cnt_d;

  // Triggers while counting are ignored; a trigger on the zero cycle reloads.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (trig && (cnt_q == '0)) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use hazard detector and PC/memory stall sequencer with branch-flush priority.
// Optional HAZARD_PERF_CNT_EN adds a saturating stall-cycle counter on stall_cnt.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W         = REG_W_DEF,
  parameter int unsigned NUM_SRC       = 2,
  parameter int unsigned MEM_STALL_CYC = 2,
  parameter int unsigned PC_STALL_CYC  = 2
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W         = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       memread_if_id,
  input  logic                       memread_id_ex,
  input  logic                       memwrite_ex_mem,
  input  logic                       regwrite_id_ex,
  input  logic [REG_W-1:0]           dst_reg_id_ex,
  input  logic [NUM_SRC*REG_W-1:0]   src_reg_if_id,
  input  logic [NUM_SRC-1:0]         src_vld_if_id,
  input  logic                       flush_req,
  output logic                       hazard,
  output logic                       stall_pc,
  output logic                       stall_mem,
  output logic                       stall_if_id,
  output logic                       bubble_id_ex,
  output logic                       flush_if_id
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]           stall_cnt
`endif
);

  logic [NUM_SRC-1:0] src_hit;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_hit[i] = src_vld_if_id[i] &
                        (src_reg_if_id[i*REG_W +: REG_W] == dst_reg_id_ex);
  end

  always_comb begin
    hazard = ~flush_req & memread_id_ex & regwrite_id_ex &
             (dst_reg_id_ex != REG_W'(ZERO_REG)) & (|src_hit);
    stall_if_id  = hazard | stall_mem;
    bubble_id_ex = hazard;
    flush_if_id  = flush_req;
  end

  // The memory op in flight always completes, so flush never clears this timer.
  stall_timer #(
    .CYC (MEM_STALL_CYC)
  ) u_mem_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .trig (memread_id_ex | memwrite_ex_mem),
    .busy (stall_mem)
  );

  stall_timer #(
    .CYC (PC_STALL_CYC)
  ) u_pc_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush_req),
    .trig (memread_if_id | memread_id_ex),
    .busy (stall_pc)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if_id && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (default parameters).
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        memread_if_id;
  logic        memread_id_ex;
  logic        memwrite_ex_mem;
  logic        regwrite_id_ex;
  logic [4:0]  dst_reg_id_ex;
  logic [9:0]  src_reg_if_id;
  logic [1:0]  src_vld_if_id;
  logic        flush_req;
  logic        hazard;
  logic        stall_pc;
  logic        stall_mem;
  logic        stall_if_id;
  logic        bubble_id_ex;
  logic        flush_if_id;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .memread_if_id   (memread_if_id),
    .memread_id_ex   (memread_id_ex),
    .memwrite_ex_mem (memwrite_ex_mem),
    .regwrite_id_ex  (regwrite_id_ex),
    .dst_reg_id_ex   (dst_reg_id_ex),
    .src_reg_if_id   (src_reg_if_id),
    .src_vld_if_id   (src_vld_if_id),
    .flush_req       (flush_req),
    .hazard          (hazard),
    .stall_pc        (stall_pc),
    .stall_mem       (stall_mem),
    .stall_if_id     (stall_if_id),
    .bubble_id_ex    (bubble_id_ex),
    .flush_if_id     (flush_if_id)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    memread_if_id   = 1'b0;
    memread_id_ex   = 1'b0;
    memwrite_ex_mem = 1'b0;
    regwrite_id_ex  = 1'b0;
    dst_reg_id_ex   = 5'd0;
    src_reg_if_id   = 10'd0;
    src_vld_if_id   = 2'b00;
    flush_req       = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (stall_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall_pc: got %b want 0", stall_pc);
    end
    n_tests++;
    if (stall_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall_mem: got %b want 0", stall_mem);
    end
    n_tests++;
    if (hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hazard: got %b want 0", hazard);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_tests++;
    if (stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
`endif
  endtask

  // Combinational checks are done with rst held so no counter can load.
  task automatic test_hazard();
    logic [4:0] dst_v  [7];
    logic [9:0] src_v  [7];
    logic [1:0] vld_v  [7];
    logic       rw_v   [7];
    logic       mr_v   [7];
    logic       fl_v   [7];
    logic       exp_v  [7];
    dst_v = '{5'd5, 5'd5, 5'd0,  5'd5, 5'd5, 5'd5, 5'd5};
    src_v = '{{5'd0, 5'd5}, {5'd0, 5'd5}, {5'd0, 5'd0}, {5'd0, 5'd5},
              {5'd5, 5'd3}, {5'd0, 5'd5}, {5'd0, 5'd5}};
    vld_v = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01};
    rw_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    mr_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    fl_v  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      dst_reg_id_ex  = dst_v[i];
      src_reg_if_id  = src_v[i];
      src_vld_if_id  = vld_v[i];
      regwrite_id_ex = rw_v[i];
      memread_id_ex  = mr_v[i];
      flush_req      = fl_v[i];
      #1;
      n_tests++;
      if (hazard !== exp_v[i]) begin
        n_fail++;
        $display("FAIL hazard_vec%0d: got %b want %b", i, hazard, exp_v[i]);
      end
      n_tests++;
      if (bubble_id_ex !== exp_v[i] || stall_if_id !== exp_v[i]) begin
        n_fail++;
        $display("FAIL hazard_ctl_vec%0d: bubble %b stall_if_id %b want %b",
                 i, bubble_id_ex, stall_if_id, exp_v[i]);
      end
      n_tests++;
      if (flush_if_id !== fl_v[i]) begin
        n_fail++;
        $display("FAIL flush_if_id_vec%0d: got %b want %b", i, flush_if_id, fl_v[i]);
      end
    end
    tick();
    clear_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mem_stall();
    logic exp_v [4];
    exp_v = '{1'b1, 1'b1, 1'b0, 1'b0};
    memread_id_ex = 1'b1;
    tick();
    memread_id_ex = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (stall_mem !== exp_v[i]) begin
        n_fail++;
        $display("FAIL mem_stall_c%0d: got %b want %b", i + 1, stall_mem, exp_v[i]);
      end
      // Repeat trigger during the stall must not extend it.
      memwrite_ex_mem = (i == 0);
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_flush_pc();
    memread_if_id = 1'b1;
    tick();
    memread_if_id = 1'b0;
    flush_req     = 1'b1;
    n_tests++;
    if (stall_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pc_n1: got %b want 1", stall_pc);
    end
    tick();
    flush_req = 1'b0;
    n_tests++;
    if (stall_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_pc_n2: got %b want 0", stall_pc);
    end
    // Flush beats a same-cycle trigger.
    memread_if_id = 1'b1;
    flush_req     = 1'b1;
    tick();
    clear_inputs();
    n_tests++;
    if (stall_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_beats_trig: got %b want 0", stall_pc);
    end
    // Flush clears the PC timer but leaves the memory timer running.
    memread_id_ex = 1'b1;
    tick();
    memread_id_ex = 1'b0;
    flush_req     = 1'b1;
    tick();
    flush_req = 1'b0;
    n_tests++;
    if (stall_pc !== 1'b0 || stall_mem !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_keeps_mem: pc %b mem %b want pc 0 mem 1", stall_pc, stall_mem);
    end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_v [6];
    exp_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    memwrite_ex_mem = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (stall_mem !== exp_v[i]) begin
        n_fail++;
        $display("FAIL b2b_c%0d: got %b want %b", i, stall_mem, exp_v[i]);
      end
    end
    clear_inputs();
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    memread_id_ex = 1'b1;
    tick();
    memread_id_ex = 1'b0;
    n_tests++;
    if (stall_pc !== 1'b1 || stall_mem !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst_stall: pc %b mem %b want 1 1", stall_pc, stall_mem);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (stall_pc !== 1'b0 || stall_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_stall: pc %b mem %b want 0 0", stall_pc, stall_mem);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (stall_pc !== 1'b0 || stall_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_stall: pc %b mem %b want 0 0", stall_pc, stall_mem);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_tests++;
    if (stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt);
    end
    // Hazard held across three edges: stall_if_id is high before each.
    dst_reg_id_ex  = 5'd5;
    src_reg_if_id  = {5'd0, 5'd5};
    src_vld_if_id  = 2'b01;
    regwrite_id_ex = 1'b1;
    memread_id_ex  = 1'b1;
    tick();
    tick();
    tick();
    clear_inputs();
    n_tests++;
    if (stall_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL stall_cnt_count: got %0d want 3", stall_cnt);
    end
    tick();
    n_tests++;
    if (stall_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL stall_cnt_hold: got %0d want 3", stall_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_mem_stall();
    test_flush_pc();
    test_back_to_back();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
